// File: rtl/mac_accumulator.sv
// Signed Q(DATA_W-FRAC_W).FRAC_W multiply-accumulate stage: accumulates vec_len products onto a bias
// and emits one saturated result per job. Define MAC_ACCUMULATOR_RELU_EN to clamp negative results to zero.
module mac_accumulator #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [DATA_W-1:0] bias_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] act_in,
  input  logic [DATA_W-1:0] wgt_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              sat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                drain_q, drain_d;
  logic [LEN_W-1:0]    vecLen_q;
  logic [LEN_W-1:0]    count_q;
  logic [DATA_W-1:0]   act_q, wgt_q;
  logic                opValid_q;
  logic [2*DATA_W-1:0] prod_q;
  logic                prodValid_q;
  logic [ACC_W-1:0]    acc_q;
  logic                outValid_q;
  logic [DATA_W-1:0]   result_q;
  logic                sat_q;

  logic                beat;
  logic                jobStart;
  logic [2*DATA_W-1:0] prodNext;
  logic [ACC_W-1:0]    prodExt;
  logic [ACC_W-1:0]    biasExt;
  logic [DATA_W-1:0]   satResult;
  logic                satFlag;
  logic                unusedFracBits;

  assign in_ready  = (state_q == ACC) && (count_q < vecLen_q);
  assign beat      = in_valid && in_ready;
  assign jobStart  = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign result    = result_q;
  assign sat       = sat_q;

  assign prodNext = $signed({{DATA_W{act_q[DATA_W-1]}}, act_q}) *
                    $signed({{DATA_W{wgt_q[DATA_W-1]}}, wgt_q});
  assign prodExt  = {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
  assign biasExt  = {{(ACC_W-DATA_W-FRAC_W){bias_in[DATA_W-1]}}, bias_in, {FRAC_W{1'b0}}};

  // Fraction bits below the result LSB are simply truncated by the arithmetic shift.
  assign unusedFracBits = ^acc_q[FRAC_W-1:0];

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (vec_len == '0) ? DRAIN : ACC;
          drain_d = 1'b0;
        end
      end
      ACC: begin
        if ((count_q == vecLen_q) && !beat) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE: begin
        if (outValid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The value fits when every bit from the result sign upward agrees; otherwise clip by the sign.
  always_comb begin
    satResult = acc_q[FRAC_W+DATA_W-1:FRAC_W];
    satFlag   = 1'b0;
    if (!((&acc_q[ACC_W-1:FRAC_W+DATA_W-1]) || !(|acc_q[ACC_W-1:FRAC_W+DATA_W-1]))) begin
      satFlag   = 1'b1;
      satResult = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`ifdef MAC_ACCUMULATOR_RELU_EN
    if (satResult[DATA_W-1]) satResult = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      vecLen_q    <= '0;
      count_q     <= '0;
      act_q       <= '0;
      wgt_q       <= '0;
      opValid_q   <= 1'b0;
      prod_q      <= '0;
      prodValid_q <= 1'b0;
      acc_q       <= '0;
      outValid_q  <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;

      if (jobStart) begin
        vecLen_q <= vec_len;
        count_q  <= '0;
      end else if (beat) begin
        count_q <= count_q + LEN_W'(1);
      end

      opValid_q <= beat;
      if (beat) begin
        act_q <= act_in;
        wgt_q <= wgt_in;
      end

      prodValid_q <= opValid_q;
      if (opValid_q) prod_q <= prodNext;

      if (jobStart)         acc_q <= biasExt;
      else if (prodValid_q) acc_q <= acc_q + prodExt;

      if ((state_q == DRAIN) && drain_q) begin
        outValid_q <= 1'b1;
        result_q   <= satResult;
        sat_q      <= satFlag;
      end else if ((state_q == DONE) && out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

endmodule
